regfile_wb_scheduler: RTL and testbench

Writeback scheduler and scoreboard for the 32×32 integer register file. It shares the file's single write port (waddr/wdata/we) between the ALU and load/store writeback requesters using round-robin arbitration. It tracks in-flight destination registers so decode can stall on read-after-write hazards. It sits between execute/memory writeback and the register file, and drives the file's write port from registers.

---
 rtl/regfile_wb_scheduler_if.sv | 50 +++++
 rtl/regfile_wb_scheduler.sv | 106 ++++++++++
 tb/tb_regfile_wb_scheduler.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_scheduler_if.sv
// rtl/regfile_wb_scheduler_if.sv - handshake bundle between decode, writeback requesters, register file and the scheduler
//
// Groups the issue/hazard-check channel, the ALU and LSU writeback request
// channels, the register-file write port and the busy vector.
//   slave  : the scheduler side (regfile_wb_scheduler)
//   master : the environment side (decode, execute/memory, register file)
interface regfile_wb_scheduler_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32
);
    localparam int RW = $clog2(NREG);

    logic            issue_valid;
    logic [RW-1:0]   issue_rd;
    logic            issue_ready;
    logic [RW-1:0]   chk_rs1;
    logic [RW-1:0]   chk_rs2;
    logic            stall;

    logic            alu_valid;
    logic            alu_ready;
    logic [RW-1:0]   alu_rd;
    logic [XLEN-1:0] alu_data;

    logic            lsu_valid;
    logic            lsu_ready;
    logic [RW-1:0]   lsu_rd;
    logic [XLEN-1:0] lsu_data;

    logic            rf_we;
    logic [RW-1:0]   rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic [NREG-1:0] busy;

    modport slave (
        input  issue_valid, issue_rd, chk_rs1, chk_rs2,
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        output issue_ready, stall, alu_ready, lsu_ready,
        output rf_we, rf_waddr, rf_wdata, busy
    );

    modport master (
        output issue_valid, issue_rd, chk_rs1, chk_rs2,
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        input  issue_ready, stall, alu_ready, lsu_ready,
        input  rf_we, rf_waddr, rf_wdata, busy
    );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// rtl/regfile_wb_scheduler.sv - round-robin writeback arbiter and RAW scoreboard for the integer register file
//
// Shares the register file's single write port between the ALU and LSU
// writeback requesters and keeps a 2-bit in-flight count per destination
// register so decode can stall on read-after-write hazards.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   bus (slave modport):
//     issue_valid/rd/ready  decode issue of an instruction writing issue_rd
//     chk_rs1/chk_rs2       decode source registers; stall flags a hazard
//     alu_*/lsu_*           writeback requests, ready is the combinational grant
//     rf_we/waddr/wdata     registered register-file write port
//     busy                  per-register in-flight flag (bit 0 always 0)
module regfile_wb_scheduler #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input logic                   clk,
    input logic                   rst_n,
    regfile_wb_scheduler_if.slave bus
);
    localparam int RW = $clog2(NREG);

    // 0: ALU granted last, 1: LSU granted last
    logic                 last_grant;
    logic [NREG-1:0][1:0] pending;
    logic [NREG-1:0][1:0] pending_nxt;
    logic [NREG-1:0]      issue_hit;
    logic [NREG-1:0]      wb_hit;
    logic [NREG-1:0]      busy_vec;

    logic                 alu_fire;
    logic                 lsu_fire;
    logic                 wb_fire;
    logic                 issue_fire;
    logic [RW-1:0]        wb_rd;
    logic [XLEN-1:0]      wb_data;

    // A lone requester always wins; on conflict the side not served last wins.
    // Grants are held low during reset so nothing is consumed.
    assign bus.alu_ready = rst_n && bus.alu_valid && (!bus.lsu_valid || last_grant);
    assign bus.lsu_ready = rst_n && bus.lsu_valid && (!bus.alu_valid || !last_grant);

    assign alu_fire = bus.alu_valid && bus.alu_ready;
    assign lsu_fire = bus.lsu_valid && bus.lsu_ready;
    assign wb_fire  = alu_fire || lsu_fire;
    assign wb_rd    = lsu_fire ? bus.lsu_rd   : bus.alu_rd;
    assign wb_data  = lsu_fire ? bus.lsu_data : bus.alu_data;

    // x0 never counts, so it is always ready to issue.
    assign bus.issue_ready = rst_n && ((bus.issue_rd == '0) || (pending[bus.issue_rd] != 2'd3));
    assign issue_fire      = bus.issue_valid && bus.issue_ready && (bus.issue_rd != '0);

    assign issue_hit = issue_fire ? (NREG'(1) << bus.issue_rd) : '0;
    assign wb_hit    = wb_fire ? ((NREG'(1) << wb_rd) & ~NREG'(1)) : '0;

    always_comb begin
        pending_nxt    = pending;
        pending_nxt[0] = 2'd0;
        for (int i = 1; i < NREG; i++) begin
            if (issue_hit[i] && !wb_hit[i]) begin
                pending_nxt[i] = pending[i] + 2'd1;
            end else if (wb_hit[i] && !issue_hit[i] && (pending[i] != 2'd0)) begin
                // a stray writeback to an idle register must not wrap to 3
                pending_nxt[i] = pending[i] - 2'd1;
            end
        end
    end

    always_comb begin
        busy_vec = '0;
        for (int i = 1; i < NREG; i++) begin
            busy_vec[i] = (pending[i] != 2'd0);
        end
    end

    assign bus.busy  = busy_vec;
    assign bus.stall = ((bus.chk_rs1 != '0) && busy_vec[bus.chk_rs1]) ||
                       ((bus.chk_rs2 != '0) && busy_vec[bus.chk_rs2]);

    // Counters drop on the same edge that raises rf_we, so decode sees the
    // register free exactly when the file's write bypass supplies the value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rf_we    <= 1'b0;
            bus.rf_waddr <= '0;
            bus.rf_wdata <= '0;
            last_grant   <= 1'b0;
        end else begin
            bus.rf_we <= wb_fire && (wb_rd != '0);
            if (wb_fire) begin
                bus.rf_waddr <= wb_rd;
                bus.rf_wdata <= wb_data;
                last_grant   <= lsu_fire;
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb/tb_regfile_wb_scheduler.sv - self-checking bench for regfile_wb_scheduler
module tb_regfile_wb_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_wb_scheduler_if #(.XLEN(32), .NREG(32)) bus ();

    regfile_wb_scheduler #(.XLEN(32), .NREG(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic        alu_v;
        logic [4:0]  alu_rd;
        logic [31:0] alu_d;
        logic        lsu_v;
        logic [4:0]  lsu_rd;
        logic [31:0] lsu_d;
        logic        exp_alu;
        logic        exp_lsu;
    } vec_t;

    wr_t  exp_q[$];
    vec_t tbl[11];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    // Advance one clock; any write predicted for this edge must appear now.
    task automatic tick();
        wr_t w;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            check("rf_we", 32'(bus.rf_we), 1);
            check("rf_waddr", 32'(bus.rf_waddr), 32'(w.addr));
            check("rf_wdata", bus.rf_wdata, w.data);
        end else begin
            check("rf_we_idle", 32'(bus.rf_we), 0);
        end
    endtask

    task automatic wb_cycle(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                            input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                            input logic ea, input logic el);
        bus.alu_valid = av;
        bus.alu_rd    = ard;
        bus.alu_data  = ad;
        bus.lsu_valid = lv;
        bus.lsu_rd    = lrd;
        bus.lsu_data  = ld;
        #1;
        check("alu_ready", 32'(bus.alu_ready), 32'(ea));
        check("lsu_ready", 32'(bus.lsu_ready), 32'(el));
        if (ea && ard != 5'd0) exp_q.push_back(wr_t'({ard, ad}));
        if (el && lrd != 5'd0) exp_q.push_back(wr_t'({lrd, ld}));
        tick();
        bus.alu_valid = 1'b0;
        bus.lsu_valid = 1'b0;
    endtask

    task automatic idle();
        wb_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // arbitration table; starts with ALU as last grant
        tbl[0]  = '{1'b1, 5'd1, 32'hA000_0000, 1'b1, 5'd2, 32'hB000_0000, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, 5'd1, 32'hA000_0000, 1'b1, 5'd2, 32'hB000_0001, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 5'd1, 32'hA000_0002, 1'b1, 5'd2, 32'hB000_0001, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 5'd1, 32'hA000_0002, 1'b1, 5'd2, 32'hB000_0003, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 5'd0, 32'h0000_0000, 1'b1, 5'd3, 32'hB000_0004, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 5'd0, 32'h0000_0000, 1'b1, 5'd4, 32'hB000_0005, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 5'd1, 32'hA000_0006, 1'b1, 5'd2, 32'hB000_0006, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 5'd1, 32'hA000_0007, 1'b0, 5'd2, 32'hB000_0007, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 5'd1, 32'hA000_0008, 1'b1, 5'd2, 32'hB000_0008, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 5'd0, 32'h0000_1234, 1'b0, 5'd0, 32'h0000_0000, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 5'd1, 32'hA000_000A, 1'b1, 5'd2, 32'hB000_000A, 1'b0, 1'b1};

        bus.issue_valid = 1'b0; bus.issue_rd = 5'd0;
        bus.chk_rs1 = 5'd0;     bus.chk_rs2 = 5'd0;
        bus.alu_valid = 1'b0;   bus.alu_rd = 5'd0; bus.alu_data = 32'd0;
        bus.lsu_valid = 1'b0;   bus.lsu_rd = 5'd0; bus.lsu_data = 32'd0;

        // reset state, with every requester asserting valid
        repeat (2) @(posedge clk);
        #1;
        bus.alu_valid = 1'b1; bus.lsu_valid = 1'b1; bus.issue_valid = 1'b1; bus.issue_rd = 5'd4;
        #1;
        check("rst_rf_we", 32'(bus.rf_we), 0);
        check("rst_rf_waddr", 32'(bus.rf_waddr), 0);
        check("rst_rf_wdata", bus.rf_wdata, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_stall", 32'(bus.stall), 0);
        check("rst_alu_ready", 32'(bus.alu_ready), 0);
        check("rst_lsu_ready", 32'(bus.lsu_ready), 0);
        check("rst_issue_ready", 32'(bus.issue_ready), 0);
        bus.alu_valid = 1'b0; bus.lsu_valid = 1'b0; bus.issue_valid = 1'b0; bus.issue_rd = 5'd0;
        rst_n = 1'b1;

        // single ALU writeback, then idle with held address/data
        wb_cycle(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        idle();
        check("hold_waddr", 32'(bus.rf_waddr), 5);
        check("hold_wdata", bus.rf_wdata, 32'hDEAD_BEEF);

        for (int i = 0; i < 11; i++) begin
            wb_cycle(tbl[i].alu_v, tbl[i].alu_rd, tbl[i].alu_d,
                     tbl[i].lsu_v, tbl[i].lsu_rd, tbl[i].lsu_d,
                     tbl[i].exp_alu, tbl[i].exp_lsu);
        end
        check("busy_after_stray_wb", bus.busy, 0);

        // RAW hazard on x7 cleared by an LSU writeback
        bus.chk_rs1 = 5'd7; bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
        settle();
        check("issue7_ready", 32'(bus.issue_ready), 1);
        check("stall_before_issue", 32'(bus.stall), 0);
        idle();
        bus.issue_valid = 1'b0;
        settle();
        check("busy7_set", 32'(bus.busy[7]), 1);
        check("stall7_set", 32'(bus.stall), 1);
        wb_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h0000_0077, 1'b0, 1'b1);
        check("busy7_clear", 32'(bus.busy[7]), 0);
        check("stall7_clear", 32'(bus.stall), 0);
        bus.chk_rs1 = 5'd0;

        // saturating counter on x9
        bus.chk_rs2 = 5'd9; bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
        for (int k = 0; k < 3; k++) begin
            settle();
            check("issue9_ready", 32'(bus.issue_ready), 1);
            idle();
        end
        settle();
        check("issue9_full", 32'(bus.issue_ready), 0);
        check("stall9_rs2", 32'(bus.stall), 1);
        wb_cycle(1'b1, 5'd9, 32'h0000_0099, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        settle();
        check("issue9_after_wb", 32'(bus.issue_ready), 1);
        wb_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h0000_0098, 1'b0, 1'b1);
        settle();
        check("issue9_same_rd", 32'(bus.issue_ready), 1);
        idle();
        settle();
        check("issue9_full_again", 32'(bus.issue_ready), 0);
        bus.issue_valid = 1'b0;

        // issue x10 while x9 drains, then a stray writeback to idle x9
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd10;
        wb_cycle(1'b1, 5'd9, 32'h0000_0091, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        bus.issue_valid = 1'b0;
        check("busy10_set", 32'(bus.busy[10]), 1);
        check("busy9_two_left", 32'(bus.busy[9]), 1);
        wb_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h0000_0092, 1'b0, 1'b1);
        wb_cycle(1'b1, 5'd9, 32'h0000_0093, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        check("busy9_drained", 32'(bus.busy[9]), 0);
        wb_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h0000_0094, 1'b0, 1'b1);
        check("busy9_no_underflow", 32'(bus.busy[9]), 0);
        check("stall9_clear", 32'(bus.stall), 0);
        wb_cycle(1'b1, 5'd10, 32'h0000_00A0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        check("busy_all_clear", bus.busy, 0);
        bus.chk_rs2 = 5'd0;

        // x0 writeback and issue
        wb_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h0000_1234, 1'b0, 1'b1);
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd0;
        settle();
        check("issue0_ready", 32'(bus.issue_ready), 1);
        check("stall_x0", 32'(bus.stall), 0);
        idle();
        bus.issue_valid = 1'b0;
        check("busy_x0_issue", bus.busy, 0);

        // reset in the middle of a write with x3 pending twice
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd3;
        idle();
        idle();
        bus.issue_valid = 1'b0; bus.chk_rs1 = 5'd3;
        settle();
        check("busy3_set", bus.busy, 32'h0000_0008);
        check("stall3_set", 32'(bus.stall), 1);
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd1; bus.lsu_data = 32'h0000_CAFE;
        settle();
        check("pre_rst_lsu_ready", 32'(bus.lsu_ready), 1);
        @(posedge clk);
        #1;
        bus.lsu_valid = 1'b0;
        check("pre_rst_rf_we", 32'(bus.rf_we), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rf_we", 32'(bus.rf_we), 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_stall", 32'(bus.stall), 0);
        check("mid_rst_issue_ready", 32'(bus.issue_ready), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.chk_rs1 = 5'd0;
        wb_cycle(1'b1, 5'd1, 32'h0000_00A1, 1'b1, 5'd2, 32'h0000_00B2, 1'b0, 1'b1);
        check("queue_drained", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
